// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the two-port RAM arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [1:0]        wr;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;

  modport master (
    output req, wr, addr0, addr1, wdata0, wdata1,
    input  gnt, done, rdata0, rdata1, busy
  );

  modport slave (
    input  req, wr, addr0, addr1, wdata0, wdata1,
    output gnt, done, rdata0, rdata1, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between fetch (0)
// and execute (1) ports; fixed 4-cycle IDLE/ISSUE/WAIT/DONE sequence.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_x
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win;
  logic              busy;

  // last_q doubles as the port being served while busy
  always_comb begin
    unique case (1'b1)
      bus.req == 2'b01: win = 1'b0;
      bus.req == 2'b10: win = 1'b1;
      default:          win = ~last_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d = S_ISSUE;
          last_d  = win;
          wr_d    = bus.wr[win];
          addr_d  = win ? bus.addr1 : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_DONE;
        if (!wr_q) begin
          if (last_q) rdata1_d = ram_x;
          else        rdata0_d = ram_x;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign bus.busy   = busy;
  assign bus.gnt    = (state_q == S_ISSUE) ?
                      (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done   = (state_q == S_DONE) ?
                      (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign ram_we     = (state_q == S_ISSUE) && wr_q;
  assign ram_addr   = busy ? addr_q : '0;
  assign ram_data   = busy ? wdata_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers queue requests, a negedge
// monitor predicts grants/completions from a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_x;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_x    (ram_x)
  );

  logic          rq [2];
  logic          wq [2];
  logic [AW-1:0] aq [2];
  logic [DW-1:0] dq [2];

  assign bus.req    = {rq[1], rq[0]};
  assign bus.wr     = {wq[1], wq[0]};
  assign bus.addr0  = aq[0];
  assign bus.addr1  = aq[1];
  assign bus.wdata0 = dq[0];
  assign bus.wdata1 = dq[1];

  // RAM with registered read output
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_x <= mem[ram_addr];
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // scoreboard: requests queued by drivers, consumed at predicted grants
  txn_t          req_q [2][$];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] ref_rd [2];
  int            grant_log [$];

  int            age = -1;
  logic          last_m = 1'b1;
  int            cur_port = 0;
  txn_t          cur = '0;
  logic [DW-1:0] cur_rd = '0;
  logic          prev_rst = 1'b0;
  logic [1:0]    prev_req = 2'b00;

  initial begin
    logic [31:0] exp_g;
    logic [31:0] exp_d;
    logic        act;
    forever begin
      @(negedge clk);
      cyc++;
      if (!prev_rst) begin
        if (age == 0 || age == 1) req_q[cur_port].push_front(cur);
        age       = -1;
        last_m    = 1'b1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
      end else if (age >= 0) begin
        age = (age == 2) ? -1 : age + 1;
      end else if (prev_req != 2'b00) begin
        if (prev_req == 2'b01)      cur_port = 0;
        else if (prev_req == 2'b10) cur_port = 1;
        else                        cur_port = last_m ? 0 : 1;
        last_m = (cur_port == 1);
        age = 0;
        grant_log.push_back(cur_port);
        if (req_q[cur_port].size() == 0) begin
          chk("stray_request", 1, 0);
          cur = '0;
        end else begin
          cur = req_q[cur_port].pop_front();
        end
        if (cur.wr) ref_mem[cur.addr] = cur.wdata;
        else        cur_rd = ref_mem[cur.addr];
      end
      if (age == 2 && !cur.wr) ref_rd[cur_port] = cur_rd;

      act   = (age >= 0);
      exp_g = (age == 0) ? (32'd1 << cur_port) : 32'd0;
      exp_d = (age == 2) ? (32'd1 << cur_port) : 32'd0;
      chk("gnt", bus.gnt, exp_g);
      chk("done", bus.done, exp_d);
      chk("busy", bus.busy, act);
      chk("ram_we", ram_we, (age == 0) && cur.wr);
      chk("ram_addr", ram_addr, act ? cur.addr : '0);
      chk("ram_data", ram_data, act ? cur.wdata : '0);
      chk("rdata0", bus.rdata0, ref_rd[0]);
      chk("rdata1", bus.rdata1, ref_rd[1]);

      prev_rst = rst_n;
      prev_req = bus.req;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int p);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.gnt[p] !== 1'b1 && t < 100);
    if (bus.gnt[p] !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL gnt_timeout port%0d: got no grant, required one",
               p);
    end
  endtask

  task automatic port_txn(input int p, input logic w,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit drop);
    rq[p] = 1'b1;
    wq[p] = w;
    aq[p] = a;
    dq[p] = d;
    req_q[p].push_back('{wr: w, addr: a, wdata: d});
    wait_gnt(p);
    @(posedge clk);
    #1;
    if (drop) rq[p] = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return AW'($urandom);
  endfunction

  task automatic rand_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 6)) begin
        wq[p] = 1'($urandom);
        aq[p] = AW'($urandom);
        dq[p] = DW'($urandom);
        @(posedge clk);
        #1;
      end
      port_txn(p, 1'($urandom), rand_addr(), DW'($urandom), 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      wq[i] = 1'b0;
      aq[i] = '0;
      dq[i] = '0;
    end
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    port_txn(0, 1'b1, 6'h3F, 8'hA5, 1'b1);
    port_txn(0, 1'b0, 6'h3F, 8'h00, 1'b1);
    idle(4);
    chk("rd_3f_rdata0", bus.rdata0, 8'hA5);

    port_txn(1, 1'b1, 6'h00, 8'h00, 1'b1);
    idle(4);
    chk("wr_p1_keeps_rdata0", bus.rdata0, 8'hA5);

    grant_log.delete();
    fork
      port_txn(0, 1'b0, 6'h01, 8'h00, 1'b1);
      port_txn(1, 1'b0, 6'h02, 8'h00, 1'b1);
    join
    idle(4);
    chk("tie_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("tie_first", grant_log[0], 0);
      chk("tie_second", grant_log[1], 1);
    end

    grant_log.delete();
    fork
      begin
        port_txn(1, 1'b0, 6'h05, 8'h00, 1'b0);
        port_txn(1, 1'b1, 6'h06, 8'h3C, 1'b0);
        port_txn(1, 1'b0, 6'h06, 8'h00, 1'b1);
      end
      begin
        idle(1);
        port_txn(0, 1'b0, 6'h3F, 8'h00, 1'b1);
      end
    join
    idle(4);
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("rr_g0", grant_log[0], 1);
      chk("rr_g1", grant_log[1], 0);
      chk("rr_g2", grant_log[2], 1);
      chk("rr_g3", grant_log[3], 1);
    end

    rq[0] = 1'b1;
    wq[0] = 1'b0;
    aq[0] = 6'h3F;
    dq[0] = 8'h00;
    req_q[0].push_back('{wr: 1'b0, addr: 6'h3F, wdata: 8'h00});
    wait_gnt(0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    wait_gnt(0);
    idle(1);
    rq[0] = 1'b0;
    idle(4);
    chk("rst_reread_rdata0", bus.rdata0, 8'hA5);

    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    idle(6);
    chk("pending0", req_q[0].size(), 0);
    chk("pending1", req_q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
